// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types plus the element-size helpers used by the divider.
// Element sizes are one-hot: bit0=8, bit1=16, bit2=32, bit3=64 bits.
package riscv_v_pkg;

  localparam int RISCV_V_NUM_BYTES_DATA   = 8;
  localparam int RISCV_V_NUM_VALID_OSIZES = 4;
  localparam int RISCV_V_DIV_CNT_WIDTH    = $clog2(64);

  typedef logic [RISCV_V_NUM_VALID_OSIZES-1:0]     osize_vector_t;
  typedef logic [RISCV_V_NUM_BYTES_DATA-1:0][7:0]  riscv_v_src_byte_vector_t;
  typedef logic [RISCV_V_NUM_BYTES_DATA-1:0]       riscv_v_zf_t;

  typedef struct packed {
    riscv_v_src_byte_vector_t data;
    riscv_v_zf_t              valid;
    riscv_v_src_byte_vector_t merge;
  } riscv_v_alu_data_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_FIX,
    S_DONE
  } riscv_v_div_state_t;

  function automatic int osize_to_bits(osize_vector_t o);
    if (o[3])      return 64;
    else if (o[2]) return 32;
    else if (o[1]) return 16;
    else           return 8;
  endfunction

  function automatic int osize_to_bytes(osize_vector_t o);
    return osize_to_bits(o) / 8;
  endfunction

  function automatic riscv_v_zf_t lsb_mask(osize_vector_t o);
    riscv_v_zf_t m;
    int eb;
    eb = osize_to_bytes(o);
    m  = '0;
    for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++)
      m[i] = ((i & (eb - 1)) == 0);
    return m;
  endfunction

  function automatic riscv_v_zf_t msb_mask(osize_vector_t o);
    riscv_v_zf_t m;
    int eb;
    eb = osize_to_bytes(o);
    m  = '0;
    for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++)
      m[i] = (((i + 1) & (eb - 1)) == 0);
    return m;
  endfunction

  // Copy the flag held on each element's top byte to every byte of that element.
  function automatic riscv_v_zf_t bcast_msb(riscv_v_zf_t v, osize_vector_t o);
    riscv_v_zf_t r;
    int eb;
    eb = osize_to_bytes(o);
    r  = '0;
    for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++)
      r[i] = v[i | (eb - 1)];
    return r;
  endfunction

  function automatic riscv_v_zf_t bcast_lsb(riscv_v_zf_t v, osize_vector_t o);
    riscv_v_zf_t r;
    int eb;
    eb = osize_to_bytes(o);
    r  = '0;
    for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++)
      r[i] = v[i & ~(eb - 1)];
    return r;
  endfunction

  // Two's-complement negate of the elements whose bytes have en set; carry restarts per element.
  function automatic riscv_v_src_byte_vector_t seg_negate(riscv_v_src_byte_vector_t x,
                                                          riscv_v_zf_t en,
                                                          osize_vector_t o);
    riscv_v_src_byte_vector_t r;
    riscv_v_zf_t lsb;
    logic [8:0] s;
    logic c;
    lsb = lsb_mask(o);
    r   = '0;
    c   = 1'b0;
    for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++) begin
      if (lsb[i]) c = 1'b1;
      s    = {1'b0, ~x[i]} + {8'd0, c};
      r[i] = en[i] ? s[7:0] : x[i];
      c    = s[8];
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Plain N-bit adder with carry in/out; the building block of the segmented subtractor.
module adder_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign sum  = full[N-1:0];
  assign cout = full[N];

endmodule

// File: rtl/riscv_v_div_step.sv
// One radix-2 restoring division step on every element of the vector at once.
// Purely combinational; borrows are cut at each element boundary.
module riscv_v_div_step
  import riscv_v_pkg::*;
(
  input  osize_vector_t            osize,
  input  riscv_v_src_byte_vector_t rem,
  input  riscv_v_src_byte_vector_t quo,
  input  riscv_v_src_byte_vector_t divisor,
  output riscv_v_src_byte_vector_t rem_next,
  output riscv_v_src_byte_vector_t quo_next
);

  riscv_v_zf_t              lsb;
  riscv_v_zf_t              cout_v;
  riscv_v_src_byte_vector_t rem_sh;
  riscv_v_src_byte_vector_t quo_sh;
  riscv_v_src_byte_vector_t diff;
  int                       eb;

  always_comb begin : shift
    logic cr;
    logic cq;
    eb     = osize_to_bytes(osize);
    lsb    = lsb_mask(osize);
    rem_sh = '0;
    quo_sh = '0;
    cr     = 1'b0;
    cq     = 1'b0;
    for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++) begin
      rem_sh[i] = {rem[i][6:0], lsb[i] ? quo[i | (eb - 1)][7] : cr};
      quo_sh[i] = {quo[i][6:0], lsb[i] ? 1'b0 : cq};
      cr        = rem[i][7];
      cq        = quo[i][7];
    end
  end

  // rem_sh - divisor as rem_sh + ~divisor + 1; carry-out of an element's top byte means no borrow.
  for (genvar i = 0; i < RISCV_V_NUM_BYTES_DATA; i++) begin : g_byte
    logic       cin_b;
    logic       cout_b;
    logic [7:0] diff_b;
    if (i == 0) begin : g_first
      assign cin_b = 1'b1;
    end else begin : g_chain
      assign cin_b = lsb[i] ? 1'b1 : g_byte[i-1].cout_b;
    end
    adder_nbit #(.N(8)) u_add (
      .a   (rem_sh[i]),
      .b   (~divisor[i]),
      .cin (cin_b),
      .sum (diff_b),
      .cout(cout_b)
    );
    assign diff[i]   = diff_b;
    assign cout_v[i] = cout_b;
  end

  // The bit shifted out of the remainder top makes the trial non-negative regardless of the borrow.
  always_comb begin : select
    int   mi;
    logic ge;
    rem_next = '0;
    quo_next = '0;
    for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++) begin
      mi          = i | (eb - 1);
      ge          = rem[mi][7] | cout_v[mi];
      quo_next[i] = lsb[i] ? {quo_sh[i][7:1], ge} : quo_sh[i];
      rem_next[i] = ge ? diff[i] : rem_sh[i];
    end
  end

endmodule

// File: rtl/riscv_v_divider.sv
// Multi-cycle segmented vector divider (vdivu/vdiv/vremu/vrem), N+3 cycles accept-to-result.
// Accepts only when idle; the result is held in DONE until out_ready, kill/rst abort at any time.
module riscv_v_divider
  import riscv_v_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     kill,
  input  logic                     is_signed,
  input  logic                     is_rem,
  input  osize_vector_t            osize_vector,
  input  riscv_v_alu_data_t        srca,
  input  riscv_v_alu_data_t        srcb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output riscv_v_src_byte_vector_t result,
  output riscv_v_zf_t              dz
);

  localparam int NB = RISCV_V_NUM_BYTES_DATA;

  riscv_v_div_state_t               state;
  riscv_v_div_state_t               state_next;
  logic [RISCV_V_DIV_CNT_WIDTH-1:0] cnt;
  riscv_v_src_byte_vector_t         quo;
  riscv_v_src_byte_vector_t         rem;
  riscv_v_src_byte_vector_t         dvs;
  riscv_v_src_byte_vector_t         quo_step;
  riscv_v_src_byte_vector_t         rem_step;
  riscv_v_zf_t                      bval;
  riscv_v_zf_t                      qneg;
  riscv_v_zf_t                      rneg;
  riscv_v_zf_t                      bzero;
  logic                             sgn;
  logic                             want_rem;
  osize_vector_t                    osz;
  logic                             accept;

  riscv_v_zf_t                      neg_a;
  riscv_v_zf_t                      neg_b;
  riscv_v_zf_t                      bzero_c;
  riscv_v_src_byte_vector_t         res_c;
  riscv_v_zf_t                      dz_c;

  logic unused_src;
  assign unused_src = ^{srca.valid, srca.merge, srcb.merge};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid && !kill;
        if (accept) state_next = S_PREP;
      end
      S_PREP:  state_next = S_DIV;
      S_DIV:   if (cnt == '0) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (kill) state_next = S_IDLE;
  end

  riscv_v_div_step u_step (
    .osize   (osz),
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_next(rem_step),
    .quo_next(quo_step)
  );

  // Operand signs and zero-divisor detection, evaluated on the raw operands during PREP.
  always_comb begin
    riscv_v_zf_t sa;
    riscv_v_zf_t sb;
    riscv_v_zf_t ez;
    riscv_v_zf_t lsb;
    logic        acc;
    sa  = '0;
    sb  = '0;
    ez  = '0;
    lsb = lsb_mask(osz);
    acc = 1'b1;
    for (int i = 0; i < NB; i++) begin
      sa[i] = quo[i][7];
      sb[i] = dvs[i][7];
      if (lsb[i]) acc = 1'b1;
      acc   = acc & (dvs[i] == 8'd0);
      ez[i] = acc;
    end
    neg_a   = bcast_msb(sa, osz) & {NB{sgn}};
    neg_b   = bcast_msb(sb, osz) & {NB{sgn}};
    bzero_c = bcast_msb(ez, osz);
  end

  // Zero divisor already yields rem = |a| and all-ones quotient bits; only the quotient sign needs overriding.
  always_comb begin
    riscv_v_src_byte_vector_t q_fin;
    riscv_v_src_byte_vector_t r_fin;
    riscv_v_zf_t              act;
    riscv_v_zf_t              msb;
    q_fin = seg_negate(quo, qneg, osz);
    r_fin = seg_negate(rem, rneg, osz);
    act   = bcast_lsb(bval, osz);
    msb   = msb_mask(osz);
    res_c = '0;
    dz_c  = '0;
    for (int i = 0; i < NB; i++) begin
      if (act[i]) begin
        res_c[i] = want_rem ? r_fin[i] : (bzero[i] ? 8'hFF : q_fin[i]);
        dz_c[i]  = msb[i] & bzero[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      bval     <= '0;
      qneg     <= '0;
      rneg     <= '0;
      bzero    <= '0;
      sgn      <= 1'b0;
      want_rem <= 1'b0;
      osz      <= '0;
      result   <= '0;
      dz       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            quo      <= srca.data;
            dvs      <= srcb.data;
            bval     <= srcb.valid;
            sgn      <= is_signed;
            want_rem <= is_rem;
            osz      <= osize_vector;
          end
        end
        S_PREP: begin
          quo   <= seg_negate(quo, neg_a, osz);
          dvs   <= seg_negate(dvs, neg_b, osz);
          qneg  <= neg_a ^ neg_b;
          rneg  <= neg_a;
          bzero <= bzero_c;
          rem   <= '0;
          cnt   <= RISCV_V_DIV_CNT_WIDTH'(osize_to_bits(osz) - 1);
        end
        S_DIV: begin
          quo <= quo_step;
          rem <= rem_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          if (!kill) begin
            result <= res_c;
            dz     <= dz_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_v_divider.sv
// Directed bench for riscv_v_divider: hand-computed quotients/remainders, latency, backpressure, kill and reset.
module tb_riscv_v_divider;
  import riscv_v_pkg::*;

  localparam osize_vector_t O8  = 4'b0001;
  localparam osize_vector_t O16 = 4'b0010;
  localparam osize_vector_t O32 = 4'b0100;
  localparam osize_vector_t O64 = 4'b1000;

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic                     kill;
  logic                     is_signed;
  logic                     is_rem;
  osize_vector_t            osize_vector;
  riscv_v_alu_data_t        srca;
  riscv_v_alu_data_t        srcb;
  logic                     out_valid;
  logic                     out_ready;
  riscv_v_src_byte_vector_t result;
  riscv_v_zf_t              dz;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  riscv_v_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .kill        (kill),
    .is_signed   (is_signed),
    .is_rem      (is_rem),
    .osize_vector(osize_vector),
    .srca        (srca),
    .srcb        (srcb),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .dz          (dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic sg, input logic rm, input osize_vector_t os,
                         input logic [63:0] a, input logic [63:0] b, input logic [7:0] bv);
    is_signed    = sg;
    is_rem       = rm;
    osize_vector = os;
    srca.data    = a;
    srca.valid   = 8'hFF;
    srca.merge   = '0;
    srcb.data    = b;
    srcb.valid   = bv;
    srcb.merge   = '0;
  endtask

  // lat counts cycles from the accept cycle T; it equals N+3 when out_valid first shows.
  task automatic do_op(input logic sg, input logic rm, input osize_vector_t os,
                       input logic [63:0] a, input logic [63:0] b, input logic [7:0] bv,
                       output int l);
    int w;
    set_ops(sg, rm, os, a, b, bv);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    kill         = 1'b0;
    out_ready    = 1'b0;
    is_signed    = 1'b0;
    is_rem       = 1'b0;
    osize_vector = O8;
    srca         = '0;
    srcb         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8-bit unsigned: 100/7, 255/16, 5/9, 200/200, 0/1
    do_op(1'b0, 1'b0, O8, 64'h00000000_C805FF64, 64'h01010101_C8091007, 8'hFF, lat);
    check("u8_latency", 64'(lat), 64'd11);
    check("u8_quo", result, 64'h00000000_01000F0E);
    check("u8_quo_dz", 64'(dz), 64'd0);
    release_out();
    check("u8_idle_after_ack", 64'(in_ready), 64'd1);
    check("u8_valid_drop", 64'(out_valid), 64'd0);
    do_op(1'b0, 1'b1, O8, 64'h00000000_C805FF64, 64'h01010101_C8091007, 8'hFF, lat);
    check("u8_rem", result, 64'h00000000_00050F02);
    release_out();

    // 8-bit signed: -7/2, -128/-1 overflow, 20/-6, 7/0
    do_op(1'b1, 1'b0, O8, 64'h00000000_071480F9, 64'h01010101_00FAFF02, 8'hFF, lat);
    check("s8_quo", result, 64'h00000000_FFFD80FD);
    check("s8_quo_dz", 64'(dz), 64'h08);
    release_out();
    do_op(1'b1, 1'b1, O8, 64'h00000000_071480F9, 64'h01010101_00FAFF02, 8'hFF, lat);
    check("s8_rem", result, 64'h00000000_070200FF);
    check("s8_rem_dz", 64'(dz), 64'h08);
    release_out();

    // 32-bit unsigned: 0x25/0 and 0x1000/0x10
    do_op(1'b0, 1'b0, O32, 64'h00001000_00000025, 64'h00000010_00000000, 8'hFF, lat);
    check("u32_latency", 64'(lat), 64'd35);
    check("u32_quo", result, 64'h00000100_FFFFFFFF);
    check("u32_quo_dz", 64'(dz), 64'h08);
    release_out();
    do_op(1'b0, 1'b1, O32, 64'h00001000_00000025, 64'h00000010_00000000, 8'hFF, lat);
    check("u32_rem", result, 64'h00000000_00000025);
    check("u32_rem_dz", 64'(dz), 64'h08);
    release_out();

    // 64-bit signed overflow
    do_op(1'b1, 1'b0, O64, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, lat);
    check("s64_latency", 64'(lat), 64'd67);
    check("s64_quo", result, 64'h80000000_00000000);
    check("s64_quo_dz", 64'(dz), 64'd0);
    release_out();
    do_op(1'b1, 1'b1, O64, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, lat);
    check("s64_rem", result, 64'd0);
    release_out();

    // 16-bit with lanes 1 and 2 inactive (lane 1 also has a zero divisor), then backpressure
    do_op(1'b0, 1'b0, O16, 64'h1234_0064_FFFF_03E8, 64'h0002_000A_0000_0007, 8'b0100_0001, lat);
    check("u16_latency", 64'(lat), 64'd19);
    check("u16_quo", result, 64'h091A_0000_0000_008E);
    check("u16_dz", 64'(dz), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result", result, 64'h091A_0000_0000_008E);
    end
    release_out();

    // kill in the third DIV cycle, then a fresh request one cycle later
    set_ops(1'b0, 1'b0, O8, 64'h00000000_C805FF64, 64'h01010101_C8091007, 8'hFF);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_in_ready", 64'(in_ready), 64'd1);
    check("kill_out_valid", 64'(out_valid), 64'd0);
    check("kill_result_held", result, 64'h091A_0000_0000_008E);
    @(posedge clk); #1;
    check("kill_no_valid", 64'(out_valid), 64'd0);
    do_op(1'b1, 1'b0, O8, 64'h00000000_071480F9, 64'h01010101_00FAFF02, 8'hFF, lat);
    check("post_kill_latency", 64'(lat), 64'd11);
    check("post_kill_quo", result, 64'h00000000_FFFD80FD);
    release_out();

    // reset in the middle of a division
    set_ops(1'b0, 1'b0, O16, 64'h1234_0064_FFFF_03E8, 64'h0002_000A_0003_0007, 8'hFF);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_dz", 64'(dz), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
